interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
Parametrised successor to the decode block's fixed vector_operations path. Arbitrates reset, NMI, BRK and up to NUM_IRQ level-sensitive IRQ sources, then runs the 5-cycle stack-push / vector-fetch sequence. Issues registered per-cycle strobes to the bus, stack and PC logic. Sits between the external interrupt pins and instruction_decode, and takes over control only at instruction boundaries.

Parameters:
NUM_IRQ, 4, number of active-low IRQ inputs; legal range 1..8; lower index has higher priority
VEC_NMI, 16'hFFFA, NMI vector low-byte address
VEC_RES, 16'hFFFC, reset vector low-byte address
VEC_IRQ, 16'hFFFE, shared IRQ/BRK vector low-byte address
IRQ_VEC_BASE, 16'hFFE0, base of per-source vectors; used only with IRQ_VECTORED_EN

Ports:
fclk  in  1  system clock; all state changes on rising edge
resb  in  1  asynchronous active-low reset
rdy  in  1  0 stalls the sequencer; state and outputs hold
nmib  in  1  active-low NMI, falling-edge sensitive
irqb_vec  in  NUM_IRQ  active-low IRQ lines, level sensitive
i_flag  in  1  current P.I; masks IRQs, never NMI/BRK
brk_req  in  1  decode has a BRK opcode in flight
insn_boundary  in  1  decode is at the last cycle of an instruction
seq_active  out  1  sequencer owns the bus (any state except IDLE)
seq_step  out  3  current state encoding, for trace
push_pch, push_pcl, push_psr  out  1 each  stack-cycle strobes
vec_fetch_lo, vec_fetch_hi  out  1 each  vector-fetch strobes
vector_addr  out  16  address for the current vector fetch (lo, or lo+1)
sp_decrement  out  1  decrement SP this cycle
b_flag_out  out  1  B bit value to push with P
set_i, clear_d  out  1 each  one-cycle flag-update strobes
rwb  out  1  1 = read; 0 during real pushes
vpb  out  1  active-low vector pull, asserted during vector fetches
src_id  out  3  index of the accepted IRQ source
nmi_pending  out  1  latched NMI edge not yet serviced

Behaviour:
- Clock and reset: one clock, fclk. Reset resb is asynchronous and active-low.
- Reset values while resb=0:
  - state = RST; nmi_pending = 0; src_id = 0; vector_addr = VEC_RES.
  - All strobes = 0; rwb = 1; vpb = 1; seq_active = 1; nmib sync register = 1.
- States: IDLE, RST, PUSH_H, PUSH_L, PUSH_P, VEC_LO, VEC_HI.
- Reset entry: first fclk edge after resb releases goes RST -> PUSH_H with kind = RESET.
- NMI detect: nmib passes through one sync flop. Sync-flop high and nmib low sets nmi_pending.
  - An edge arriving during an active sequence stays pending.
- IRQ request: irq_req = |(~irqb_vec) & ~i_flag.
- Acceptance happens only when state = IDLE, insn_boundary = 1 and rdy = 1. Priority: NMI > BRK > IRQ (lowest index wins).
  - Kind, vector and src_id latch at acceptance.
  - Next cycle = PUSH_H, so first strobe latency is 1 cycle.
  - NMI acceptance clears nmi_pending on the same edge; an edge detected on that same edge wins and stays set.
- Sequence, one state per cycle while rdy = 1: PUSH_H -> PUSH_L -> PUSH_P -> VEC_LO -> VEC_HI -> IDLE.
  - Each push state asserts its push strobe and sp_decrement.
  - RESET kind: rwb = 1 in push states (dummy stack reads) with push strobes suppressed; sp_decrement is still asserted.
  - Other kinds: rwb = 0 in push states.
  - b_flag_out = 1 only for BRK, else 0. It is valid in PUSH_P.
  - VEC_LO: vec_fetch_lo = 1, vpb = 0, set_i = 1, clear_d = 1, vector_addr = latched vector.
  - VEC_HI: vec_fetch_hi = 1, vpb = 0, vector_addr = latched vector + 1.
- rdy = 0: state and all registered outputs hold, including the mid-push values.
- No vector hijack: the latched vector does not change after acceptance.
- IRQ line deasserting mid-sequence: the sequence completes unchanged.
- resb asserted mid-sequence: immediate abort to RST.
- brk_req and IRQ both present at a boundary: BRK is taken and the IRQ is re-evaluated at the next boundary.

Optional Feature:
INTERRUPT_SEQUENCER_IRQ_VECTORED_EN (the IRQ_VECTORED_EN feature).
- Defined: IRQ source i vectors to IRQ_VEC_BASE + 2*i. BRK still uses VEC_IRQ.
- Undefined: all IRQ sources use VEC_IRQ. src_id is still reported.

Decomposition:
- Package intseq_pkg holds the state enum, the kind enum (RESET/NMI/BRK/IRQ) and the default vector constants.
- One sub-module, intseq_arbiter: NMI edge detect plus priority encode. It is combinational, except for the nmib sync flop and the nmi_pending register.

Test Plan:
- Reset: hold resb=0 for 3 cycles, release -> 5 cycles later vector_addr = FFFC then FFFD with vpb = 0; rwb stays 1 throughout; exactly 3 sp_decrement pulses.
- NMI: nmib falls while the sequencer is idle, boundary pulse 2 cycles later -> PUSH_H at boundary+1; vector FFFA; b_flag_out = 0; nmi_pending clears.
- Masking and priority: irqb_vec = 4'b1001, i_flag = 1 -> no accept. Then i_flag = 0 at a boundary -> src_id = 1 and vector FFFE (with the macro: FFE2).
- BRK vs IRQ: brk_req and irqb_vec[0] low at the same boundary -> BRK taken with b_flag_out = 1; the IRQ is taken at the following boundary.
- rdy stall and late NMI: rdy = 0 for 4 cycles in PUSH_L -> outputs frozen, then resume; an NMI edge during VEC_LO -> the vector is unchanged and nmi_pending = 1 afterwards.
- Abort: resb pulsed low during PUSH_P -> asynchronous return to reset values, then a full reset sequence.

Source files
------------

// File: rtl/intseq_pkg.sv
// Shared types for the interrupt sequencer: state codes, interrupt kinds,
// default vectors and the per-state control decode.
package intseq_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RST    = 3'd1;
   localparam logic [2:0] ST_PUSH_H = 3'd2;
   localparam logic [2:0] ST_PUSH_L = 3'd3;
   localparam logic [2:0] ST_PUSH_P = 3'd4;
   localparam logic [2:0] ST_VEC_LO = 3'd5;
   localparam logic [2:0] ST_VEC_HI = 3'd6;

   typedef enum logic [1:0] {K_RESET, K_NMI, K_BRK, K_IRQ} kind_e;

   localparam logic [15:0] DEF_VEC_NMI      = 16'hFFFA;
   localparam logic [15:0] DEF_VEC_RES      = 16'hFFFC;
   localparam logic [15:0] DEF_VEC_IRQ      = 16'hFFFE;
   localparam logic [15:0] DEF_IRQ_VEC_BASE = 16'hFFE0;

   typedef struct packed {
      logic        seq_active;
      logic        push_pch;
      logic        push_pcl;
      logic        push_psr;
      logic        vec_fetch_lo;
      logic        vec_fetch_hi;
      logic        sp_decrement;
      logic        b_flag_out;
      logic        set_i;
      logic        clear_d;
      logic        rwb;
      logic        vpb;
      logic [15:0] vector_addr;
   } ctl_t;

   function automatic logic is_push(logic [2:0] st);
      return (st == ST_PUSH_H) || (st == ST_PUSH_L) || (st == ST_PUSH_P);
   endfunction

   // Reset sequences walk the push states as dummy reads: SP still moves.
   function automatic ctl_t decode_ctl(logic [2:0] st, kind_e k, logic [15:0] vec);
      ctl_t c;
      logic wr;
      wr             = is_push(st) && (k != K_RESET);
      c.seq_active   = (st != ST_IDLE);
      c.push_pch     = (st == ST_PUSH_H) && wr;
      c.push_pcl     = (st == ST_PUSH_L) && wr;
      c.push_psr     = (st == ST_PUSH_P) && wr;
      c.vec_fetch_lo = (st == ST_VEC_LO);
      c.vec_fetch_hi = (st == ST_VEC_HI);
      c.sp_decrement = is_push(st);
      c.b_flag_out   = (st == ST_PUSH_P) && (k == K_BRK);
      c.set_i        = (st == ST_VEC_LO);
      c.clear_d      = (st == ST_VEC_LO);
      c.rwb          = !wr;
      c.vpb          = !((st == ST_VEC_LO) || (st == ST_VEC_HI));
      c.vector_addr  = (st == ST_VEC_HI) ? vec + 16'd1 : vec;
      return c;
   endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Pin-side requests and control strobes of the interrupt sequencer.
// slave = the sequencer, master = whoever drives the pins / consumes strobes.
interface interrupt_sequencer_if #(parameter int NUM_IRQ = 4);
   logic               rdy;
   logic               nmib;
   logic [NUM_IRQ-1:0] irqb_vec;
   logic               i_flag;
   logic               brk_req;
   logic               insn_boundary;

   logic               seq_active;
   logic [2:0]         seq_step;
   logic               push_pch, push_pcl, push_psr;
   logic               vec_fetch_lo, vec_fetch_hi;
   logic [15:0]        vector_addr;
   logic               sp_decrement;
   logic               b_flag_out;
   logic               set_i, clear_d;
   logic               rwb;
   logic               vpb;
   logic [2:0]         src_id;
   logic               nmi_pending;

   modport slave (
      input  rdy, nmib, irqb_vec, i_flag, brk_req, insn_boundary,
      output seq_active, seq_step, push_pch, push_pcl, push_psr,
             vec_fetch_lo, vec_fetch_hi, vector_addr, sp_decrement,
             b_flag_out, set_i, clear_d, rwb, vpb, src_id, nmi_pending
   );

   modport master (
      output rdy, nmib, irqb_vec, i_flag, brk_req, insn_boundary,
      input  seq_active, seq_step, push_pch, push_pcl, push_psr,
             vec_fetch_lo, vec_fetch_hi, vector_addr, sp_decrement,
             b_flag_out, set_i, clear_d, rwb, vpb, src_id, nmi_pending
   );
endinterface

// File: rtl/intseq_arbiter.sv
// NMI edge capture plus NMI > BRK > IRQ priority select.
// INTERRUPT_SEQUENCER_IRQ_VECTORED_EN gives each IRQ source its own vector.
module intseq_arbiter
   import intseq_pkg::*;
#(
   parameter int          NUM_IRQ      = 4,
   parameter logic [15:0] VEC_NMI      = DEF_VEC_NMI,
   parameter logic [15:0] VEC_IRQ      = DEF_VEC_IRQ,
   parameter logic [15:0] IRQ_VEC_BASE = DEF_IRQ_VEC_BASE
) (
   input  logic               fclk,
   input  logic               resb,
   input  logic               nmib_i,
   input  logic [NUM_IRQ-1:0] irqb_vec_i,
   input  logic               i_flag_i,
   input  logic               brk_req_i,
   input  logic               accept_i,
   output logic               take_o,
   output kind_e              kind_o,
   output logic [2:0]         src_id_o,
   output logic [15:0]        vec_o,
   output logic               nmi_pending_o
);

   logic               nmib_sync_q;
   logic               nmi_pending_q, nmi_pending_d;
   logic [NUM_IRQ-1:0] irq_act;
   logic [2:0]         irq_src;
   logic [15:0]        irq_vec;

   // A new edge on the accepting edge wins over the clear.
   assign nmi_pending_d = (nmib_sync_q & ~nmib_i) | (nmi_pending_q & ~accept_i);

   always_ff @(posedge fclk or negedge resb) begin
      if (!resb) begin
         nmib_sync_q   <= 1'b1;
         nmi_pending_q <= 1'b0;
      end else begin
         nmib_sync_q   <= nmib_i;
         nmi_pending_q <= nmi_pending_d;
      end
   end

   always_comb begin
      irq_act = ~irqb_vec_i & {NUM_IRQ{~i_flag_i}};
      irq_src = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (irq_act[i]) irq_src = 3'(i);
   end

`ifdef INTERRUPT_SEQUENCER_IRQ_VECTORED_EN
   assign irq_vec = IRQ_VEC_BASE + {12'd0, irq_src, 1'b0};
`else
   logic unused_vec_base;
   assign unused_vec_base = ^IRQ_VEC_BASE;
   assign irq_vec         = VEC_IRQ;
`endif

   always_comb begin
      take_o   = nmi_pending_q | brk_req_i | (|irq_act);
      kind_o   = K_IRQ;
      src_id_o = irq_src;
      vec_o    = irq_vec;
      if (nmi_pending_q) begin
         kind_o   = K_NMI;
         src_id_o = '0;
         vec_o    = VEC_NMI;
      end else if (brk_req_i) begin
         kind_o   = K_BRK;
         src_id_o = '0;
         vec_o    = VEC_IRQ;
      end
   end

   assign nmi_pending_o = nmi_pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer top: accepts at instruction boundaries, then runs the
// 5-cycle push/vector sequence with registered strobes.
module interrupt_sequencer
   import intseq_pkg::*;
#(
   parameter int          NUM_IRQ      = 4,
   parameter logic [15:0] VEC_NMI      = DEF_VEC_NMI,
   parameter logic [15:0] VEC_RES      = DEF_VEC_RES,
   parameter logic [15:0] VEC_IRQ      = DEF_VEC_IRQ,
   parameter logic [15:0] IRQ_VEC_BASE = DEF_IRQ_VEC_BASE
) (
   input  logic                  fclk,
   input  logic                  resb,
   interrupt_sequencer_if.slave  bus
);

   logic [2:0]  state_q, state_d;
   kind_e       kind_q, kind_d;
   logic [2:0]  src_q, src_d;
   logic [15:0] vec_q, vec_d;
   ctl_t        ctl_q;

   logic        accept;
   logic        take;
   kind_e       arb_kind;
   logic [2:0]  arb_src;
   logic [15:0] arb_vec;
   logic        nmi_pending;

   assign accept = (state_q == ST_IDLE) & bus.insn_boundary & bus.rdy;

   intseq_arbiter #(
      .NUM_IRQ      (NUM_IRQ),
      .VEC_NMI      (VEC_NMI),
      .VEC_IRQ      (VEC_IRQ),
      .IRQ_VEC_BASE (IRQ_VEC_BASE)
   ) u_arb (
      .fclk          (fclk),
      .resb          (resb),
      .nmib_i        (bus.nmib),
      .irqb_vec_i    (bus.irqb_vec),
      .i_flag_i      (bus.i_flag),
      .brk_req_i     (bus.brk_req),
      .accept_i      (accept),
      .take_o        (take),
      .kind_o        (arb_kind),
      .src_id_o      (arb_src),
      .vec_o         (arb_vec),
      .nmi_pending_o (nmi_pending)
   );

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      src_d   = src_q;
      vec_d   = vec_q;
      if (bus.rdy) begin
         case (state_q)
            ST_IDLE: if (bus.insn_boundary && take) begin
               state_d = ST_PUSH_H;
               kind_d  = arb_kind;
               src_d   = arb_src;
               vec_d   = arb_vec;
            end
            ST_RST: begin
               state_d = ST_PUSH_H;
               kind_d  = K_RESET;
               src_d   = '0;
               vec_d   = VEC_RES;
            end
            ST_PUSH_H: state_d = ST_PUSH_L;
            ST_PUSH_L: state_d = ST_PUSH_P;
            ST_PUSH_P: state_d = ST_VEC_LO;
            ST_VEC_LO: state_d = ST_VEC_HI;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Strobes are decoded from the next state so they are flop outputs.
   always_ff @(posedge fclk or negedge resb) begin
      if (!resb) begin
         state_q <= ST_RST;
         kind_q  <= K_RESET;
         src_q   <= '0;
         vec_q   <= VEC_RES;
         ctl_q   <= decode_ctl(ST_RST, K_RESET, VEC_RES);
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         src_q   <= src_d;
         vec_q   <= vec_d;
         ctl_q   <= decode_ctl(state_d, kind_d, vec_d);
      end
   end

   assign bus.seq_active   = ctl_q.seq_active;
   assign bus.seq_step     = state_q;
   assign bus.push_pch     = ctl_q.push_pch;
   assign bus.push_pcl     = ctl_q.push_pcl;
   assign bus.push_psr     = ctl_q.push_psr;
   assign bus.vec_fetch_lo = ctl_q.vec_fetch_lo;
   assign bus.vec_fetch_hi = ctl_q.vec_fetch_hi;
   assign bus.vector_addr  = ctl_q.vector_addr;
   assign bus.sp_decrement = ctl_q.sp_decrement;
   assign bus.b_flag_out   = ctl_q.b_flag_out;
   assign bus.set_i        = ctl_q.set_i;
   assign bus.clear_d      = ctl_q.clear_d;
   assign bus.rwb          = ctl_q.rwb;
   assign bus.vpb          = ctl_q.vpb;
   assign bus.src_id       = src_q;
   assign bus.nmi_pending  = nmi_pending;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: stimulus queues the expected
// sequence, a negedge monitor checks each completed vector fetch.
module tb_interrupt_sequencer;
   import intseq_pkg::*;

   localparam int NI = 4;

   logic fclk = 1'b0;
   logic resb;
   always #5 fclk = ~fclk;

   interrupt_sequencer_if #(.NUM_IRQ(NI)) bus ();

   interrupt_sequencer #(.NUM_IRQ(NI)) dut (
      .fclk (fclk),
      .resb (resb),
      .bus  (bus)
   );

   typedef struct {
      logic [15:0] vec;
      logic        bflag;
      logic [2:0]  src;
      logic        rst;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [15:0] irq_vec(input int i);
`ifdef INTERRUPT_SEQUENCER_IRQ_VECTORED_EN
      return 16'hFFE0 + 16'(2 * i);
`else
      return 16'hFFFE;
`endif
   endfunction

   task automatic expect_seq(input logic [15:0] v, input logic b, input logic [2:0] s, input logic r);
      exp_t e;
      e.vec = v; e.bflag = b; e.src = s; e.rst = r;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge fclk);
      #1;
   endtask

   task automatic wait_step(input logic [2:0] s, input string nm);
      int n = 0;
      while (bus.seq_step !== s && n < 60) begin
         tick();
         n++;
      end
      chk(nm, 32'(bus.seq_step), 32'(s));
   endtask

   // Monitor: accumulate one sequence, score it when VEC_HI is consumed.
   int          spd_n, push_n, rwbl_n;
   logic        b_seen;
   logic [15:0] lo_addr;
   exp_t        mon_e;

   always @(negedge fclk) begin
      if (!resb || bus.seq_step == ST_IDLE || bus.seq_step == ST_RST) begin
         spd_n = 0; push_n = 0; rwbl_n = 0; b_seen = 1'b0; lo_addr = '0;
      end else if (bus.rdy) begin
         if (is_push(bus.seq_step)) begin
            spd_n  += int'(bus.sp_decrement);
            push_n += int'(bus.push_pch | bus.push_pcl | bus.push_psr);
            rwbl_n += int'(!bus.rwb);
         end
         if (bus.seq_step == ST_PUSH_P) b_seen = bus.b_flag_out;
         if (bus.seq_step == ST_VEC_LO) begin
            lo_addr = bus.vector_addr;
            chk("vlo_strobes", {bus.vec_fetch_lo, bus.vpb, bus.set_i, bus.clear_d}, 4'b1011);
         end
         if (bus.seq_step == ST_VEC_HI) begin
            chk("vhi_strobes", {bus.vec_fetch_hi, bus.vpb}, 2'b10);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_seq: got sequence to %0h expected none", lo_addr);
            end else begin
               mon_e = sb.pop_front();
               chk("vec_lo",   lo_addr, mon_e.vec);
               chk("vec_hi",   bus.vector_addr, mon_e.vec + 16'd1);
               chk("b_flag",   b_seen, mon_e.bflag);
               chk("src_id",   bus.src_id, mon_e.src);
               chk("sp_dec_n", spd_n, 3);
               chk("push_n",   push_n, mon_e.rst ? 0 : 3);
               chk("rwb_low_n", rwbl_n, mon_e.rst ? 0 : 3);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resb              = 1'b0;
      bus.rdy           = 1'b1;
      bus.nmib          = 1'b1;
      bus.irqb_vec      = '1;
      bus.i_flag        = 1'b1;
      bus.brk_req       = 1'b0;
      bus.insn_boundary = 1'b0;

      // reset
      expect_seq(16'hFFFC, 1'b0, 3'd0, 1'b1);
      repeat (3) tick();
      chk("rst_step", bus.seq_step, ST_RST);
      chk("rst_vec", bus.vector_addr, 16'hFFFC);
      chk("rst_ctl", {bus.seq_active, bus.rwb, bus.vpb}, 3'b111);
      chk("rst_strobes", {bus.push_pch, bus.push_pcl, bus.push_psr, bus.vec_fetch_lo,
                          bus.vec_fetch_hi, bus.sp_decrement, bus.b_flag_out,
                          bus.set_i, bus.clear_d}, 9'd0);
      chk("rst_pend_src", {bus.nmi_pending, bus.src_id}, 4'd0);
      resb = 1'b1;
      wait_step(ST_IDLE, "rst_done");

      // NMI while idle
      tick();
      bus.nmib = 1'b0;
      tick();
      chk("nmi_pend_set", bus.nmi_pending, 1'b1);
      tick();
      bus.insn_boundary = 1'b1;
      expect_seq(16'hFFFA, 1'b0, 3'd0, 1'b0);
      tick();
      bus.insn_boundary = 1'b0;
      chk("nmi_latency", bus.seq_step, ST_PUSH_H);
      chk("nmi_pend_clr", bus.nmi_pending, 1'b0);
      bus.nmib = 1'b1;
      wait_step(ST_IDLE, "nmi_done");

      // masked IRQs, then unmasked: lowest active index wins
      bus.irqb_vec = 4'b1001;
      tick();
      bus.insn_boundary = 1'b1;
      tick();
      bus.insn_boundary = 1'b0;
      chk("mask_hold", bus.seq_step, ST_IDLE);
      bus.i_flag = 1'b0;
      bus.insn_boundary = 1'b1;
      expect_seq(irq_vec(1), 1'b0, 3'd1, 1'b0);
      tick();
      bus.insn_boundary = 1'b0;
      chk("irq_latency", bus.seq_step, ST_PUSH_H);
      chk("irq_src", bus.src_id, 3'd1);
      wait_step(ST_IDLE, "irq_done");
      bus.irqb_vec = '1;

      // BRK beats a simultaneous IRQ, IRQ follows at next boundary
      bus.irqb_vec = 4'b1110;
      bus.brk_req = 1'b1;
      bus.insn_boundary = 1'b1;
      expect_seq(16'hFFFE, 1'b1, 3'd0, 1'b0);
      tick();
      bus.brk_req = 1'b0;
      bus.insn_boundary = 1'b0;
      chk("brk_latency", bus.seq_step, ST_PUSH_H);
      wait_step(ST_IDLE, "brk_done");
      bus.insn_boundary = 1'b1;
      expect_seq(irq_vec(0), 1'b0, 3'd0, 1'b0);
      tick();
      bus.insn_boundary = 1'b0;
      chk("irq0_latency", bus.seq_step, ST_PUSH_H);
      bus.irqb_vec = '1;
      wait_step(ST_IDLE, "irq0_done");

      // stall in PUSH_L with the IRQ line already released, late NMI in VEC_LO
      bus.irqb_vec = 4'b0111;
      bus.insn_boundary = 1'b1;
      expect_seq(irq_vec(3), 1'b0, 3'd3, 1'b0);
      tick();
      bus.insn_boundary = 1'b0;
      bus.irqb_vec = '1;
      tick();
      chk("stall_entry", bus.seq_step, ST_PUSH_L);
      bus.rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("stall_step", bus.seq_step, ST_PUSH_L);
         chk("stall_out", {bus.push_pch, bus.push_pcl, bus.sp_decrement, bus.rwb}, 4'b0110);
         chk("stall_vec", bus.vector_addr, irq_vec(3));
      end
      bus.rdy = 1'b1;
      wait_step(ST_VEC_LO, "stall_resume");
      bus.nmib = 1'b0;
      tick();
      chk("late_nmi_step", bus.seq_step, ST_VEC_HI);
      wait_step(ST_IDLE, "stall_done");
      chk("late_nmi_pend", bus.nmi_pending, 1'b1);
      bus.nmib = 1'b1;
      bus.insn_boundary = 1'b1;
      expect_seq(16'hFFFA, 1'b0, 3'd0, 1'b0);
      tick();
      bus.insn_boundary = 1'b0;
      wait_step(ST_IDLE, "late_nmi_done");
      chk("late_nmi_clr", bus.nmi_pending, 1'b0);

      // asynchronous abort during PUSH_P of a BRK
      bus.brk_req = 1'b1;
      bus.insn_boundary = 1'b1;
      tick();
      bus.brk_req = 1'b0;
      bus.insn_boundary = 1'b0;
      tick();
      tick();
      chk("abort_pre", bus.seq_step, ST_PUSH_P);
      chk("abort_b", bus.b_flag_out, 1'b1);
      #2 resb = 1'b0;
      #1;
      chk("abort_step", bus.seq_step, ST_RST);
      chk("abort_vec", bus.vector_addr, 16'hFFFC);
      chk("abort_ctl", {bus.seq_active, bus.rwb, bus.vpb, bus.b_flag_out, bus.sp_decrement}, 5'b11100);
      expect_seq(16'hFFFC, 1'b0, 3'd0, 1'b1);
      tick();
      resb = 1'b1;
      wait_step(ST_PUSH_H, "abort_restart");
      wait_step(ST_IDLE, "abort_done");

      tick();
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
